// File: rtl/div_pkg.sv
// Shared widths, latency and FSM encoding for the divider arbiter.
// Imported by div_arb and its picker.
package div_pkg;
    localparam int DVD_W   = 25;
    localparam int DVS_W   = 7;
    localparam int RES_W   = 50;
    localparam int DIV_LAT = 26;
    localparam logic [DVD_W-1:0] DZ_QUOT = 25'h1FFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/div_arb_rr_pick.sv
// Rotate-priority picker: first asserted request at or above ptr,
// wrapping modulo NREQ; one-hot grant plus its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/div_arb.sv
// Round-robin front end sharing one fixed-latency divider among NREQ
// requesters; zero divisors are answered locally.
module div_arb
    import div_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DIV_LAT = div_pkg::DIV_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DVD_W-1:0]    req_dividend,
    input  logic [NREQ*DVS_W-1:0]    req_divisor,
    output logic                     div_en_p,
    output logic [DVD_W-1:0]         div_dividend,
    output logic [DVS_W-1:0]         div_divisor,
    input  logic [RES_W-1:0]         div_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DVD_W-1:0]         rsp_quot,
    output logic [DVS_W-1:0]         rsp_rem,
    output logic                     rsp_dz
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DIV_LAT + 1);

    state_t           state;
    state_t           state_n;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic [DVD_W-1:0] sel_dvd;
    logic [DVS_W-1:0] sel_dvs;
    logic             accept;
    logic             unused_hi;

    // Remainder never exceeds the 7-bit divisor, so the top bits are zero.
    assign unused_hi = ^div_result[RES_W-1:DVD_W+DVS_W];

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_dvd = req_dividend[DVD_W*i +: DVD_W];
                sel_dvs = req_divisor[DVS_W*i +: DVS_W];
            end
        end
    end

    assign accept    = (state == IDLE) && (|gnt);
    assign req_ready = (state == IDLE) ? gnt : '0;
    assign div_en_p  = (state == ISSUE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (sel_dvs == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cnt          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_id       <= '0;
            rsp_quot     <= '0;
            rsp_rem      <= '0;
            rsp_dz       <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr <= (gnt_id == IDW'(NREQ - 1))
                                ? '0 : gnt_id + 1'b1;
                        div_dividend <= sel_dvd;
                        div_divisor  <= sel_dvs;
                        rsp_id       <= gnt_id;
                        if (sel_dvs == '0) begin
                            rsp_quot <= DZ_QUOT;
                            rsp_rem  <= '0;
                            rsp_dz   <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= CW'(DIV_LAT);
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_quot <= div_result[DVD_W-1:0];
                        rsp_rem  <= div_result[DVD_W +: DVS_W];
                        rsp_dz   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_arb.sv
// Directed and random bench for div_arb with a behavioural divider
// whose result is only meaningful in the cycle it lands.
module tb_div_arb;
    import div_pkg::*;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   vmask;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*25-1:0] req_dividend;
    logic [NREQ*7-1:0] req_divisor;
    logic              div_en_p;
    logic [24:0]       div_dividend;
    logic [6:0]        div_divisor;
    logic [49:0]       div_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [24:0]       rsp_quot;
    logic [6:0]        rsp_rem;
    logic              rsp_dz;

    logic [24:0] dvd [NREQ];
    logic [6:0]  dvs [NREQ];

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_dividend = '0;
        req_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[25*i +: 25] = dvd[i];
            req_divisor[7*i +: 7]    = dvs[i];
        end
    end

    div_arb #(
        .NREQ    (NREQ),
        .DIV_LAT (26)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (vmask),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .div_en_p     (div_en_p),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_result   (div_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quot     (rsp_quot),
        .rsp_rem      (rsp_rem),
        .rsp_dz       (rsp_dz)
    );

    // Divider: result lands 26 edges after the start pulse is sampled,
    // and is garbage in every other cycle.
    int dv_left = 0;
    int dv_a    = 0;
    int dv_b    = 1;

    always @(posedge clk) begin
        if (rst) begin
            dv_left = 0;
            div_result <= '0;
        end else if (div_en_p) begin
            dv_left = 26;
            dv_a = int'(div_dividend);
            dv_b = int'(div_divisor);
            div_result <= 50'({$urandom(), $urandom()});
        end else if (dv_left > 0) begin
            dv_left--;
            if (dv_left == 0 && dv_b != 0)
                div_result <= {25'(dv_a % dv_b), 25'(dv_a / dv_b)};
            else
                div_result <= 50'({$urandom(), $urandom()});
        end else begin
            div_result <= 50'({$urandom(), $urandom()});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One transaction from accept to handshake; called in an IDLE cycle.
    task automatic txn(input int stall, input bit hold, output int g);
        logic [24:0] a, eq;
        logic [6:0]  b, er;
        logic        edz;
        int cyc, en_n, en_c, lat;
        rsp_ready = (stall == 0);
        @(negedge clk);
        g = pick(vmask, ptr_m);
        chk("accept_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
        chk("accept_no_en", div_en_p, 0);
        if (g < 0) return;
        a = dvd[g];
        b = dvs[g];
        if (b == 0) begin
            eq = DZ_QUOT; er = 0; edz = 1'b1;
        end else begin
            eq = 25'(int'(a) / int'(b));
            er = 7'(int'(a) % int'(b));
            edz = 1'b0;
        end
        ptr_m = (g + 1) % NREQ;
        @(posedge clk); #1;
        if (!hold) vmask = '0;
        cyc = 1; en_n = 0; en_c = -1; lat = -1;
        while (lat < 0 && cyc <= 40) begin
            @(negedge clk);
            if (div_en_p) begin
                en_n++;
                en_c = cyc;
            end
            chk("busy_ready", req_ready, 0);
            if (rsp_valid) lat = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("latency", lat, (b == 0) ? 1 : 29);
        chk("en_count", en_n, (b == 0) ? 0 : 1);
        if (b != 0) chk("en_cycle", en_c, 1);
        chk("rsp_id", rsp_id, g);
        chk("rsp_quot", rsp_quot, eq);
        chk("rsp_rem", rsp_rem, er);
        chk("rsp_dz", rsp_dz, edz);
        if (lat < 0) return;
        for (int s = 1; s <= stall; s++) begin
            @(posedge clk); #1;
            rsp_ready = (s == stall);
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_payload", {rsp_id, rsp_quot, rsp_rem, rsp_dz},
                {2'(g), eq, er, edz});
            chk("stall_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
    endtask

    initial begin
        int g;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        vmask = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            dvd[i] = '0;
            dvs[i] = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {req_ready, div_en_p, div_dividend, div_divisor,
            rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dz}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request 1000 / 7 from requester 2
        dvd[2] = 25'd1000; dvs[2] = 7'd7; vmask = 4'b0100;
        txn(0, 0, g);
        chk("t1_gnt", g, 2);
        chk("t1_q_r", {rsp_quot, rsp_rem}, {25'd142, 7'd6});

        // Max operands
        dvd[0] = 25'h1FFFFFF; dvs[0] = 7'd127; vmask = 4'b0001;
        txn(0, 0, g);
        chk("t2_q_r", {rsp_quot, rsp_rem}, {25'd264208, 7'd15});

        // Divide by zero
        dvd[1] = 25'd12345; dvs[1] = 7'd0; vmask = 4'b0010;
        txn(0, 0, g);
        chk("t3_dz", {rsp_id, rsp_quot, rsp_rem, rsp_dz},
            {2'd1, 25'h1FFFFFF, 7'd0, 1'b1});

        // Backpressure with all requesters pending
        for (int i = 0; i < NREQ; i++) begin
            dvd[i] = 25'($urandom());
            dvs[i] = 7'($urandom_range(1, 127));
        end
        vmask = 4'hF;
        txn(5, 1, g);
        chk("t4_gnt", g, 2);
        vmask = '0;

        // Reset in the middle of WAIT
        dvd[3] = 25'd5000; dvs[3] = 7'd3; vmask = 4'b1000;
        @(negedge clk);
        chk("t5_accept", req_ready, 4'b1000);
        @(posedge clk); #1;
        vmask = '0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        chk("t5_rst_outs", {req_ready, div_en_p, div_dividend, div_divisor,
            rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dz}, 0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("t5_quiet", {rsp_valid, div_en_p}, 0);
        end
        @(posedge clk); #1;

        // Fairness, requester 0 carrying 100 / 9
        for (int i = 1; i < NREQ; i++) begin
            dvd[i] = 25'($urandom());
            dvs[i] = 7'($urandom_range(0, 127));
        end
        dvd[0] = 25'd100; dvs[0] = 7'd9; vmask = 4'hF;
        for (int f = 0; f < 5; f++) begin
            txn(0, 1, g);
            chk("fair_gnt", g, order[f]);
            if (f == 0)
                chk("t5_q_r", {rsp_quot, rsp_rem}, {25'd11, 7'd1});
        end
        vmask = '0;

        // Random traffic
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                dvd[i] = 25'($urandom());
                dvs[i] = ($urandom_range(0, 3) == 0)
                       ? 7'd0 : 7'($urandom_range(1, 127));
            end
            vmask = 4'($urandom_range(1, 15));
            txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
